// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-side handshake and line signals of the UART transmitter.
// master drives enable/start/data; slave (uart_tx) drives tx/ready/busy/done.
interface uart_tx_if #(
    parameter int NUM_DATA_BITS = 8
);
    logic                     enable;
    logic                     start;
    logic [NUM_DATA_BITS-1:0] data;
    logic                     tx;
    logic                     ready;
    logic                     busy;
    logic                     done;

    modport master (
        output enable, start, data,
        input  tx, ready, busy, done
    );

    modport slave (
        input  enable, start, data,
        output tx, ready, busy, done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serialiser with a one-entry holding register.
// Ports: baud (oversampled clock), reset (async, active high),
//   bus.slave: enable, start, data in; tx, ready, busy, done out.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD picks odd).
module uart_tx #(
    parameter int NUM_DATA_BITS = 8,
    parameter int OVERSAMPLING  = 16,
    parameter int PARITY_ODD    = 0
) (
    input  logic     baud,
    input  logic     reset,
    uart_tx_if.slave bus
);
    localparam int OS_W  = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
    localparam int BIT_W = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
    localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(NUM_DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;
`endif

    state_t                   state_q, state_d;
    logic [OS_W-1:0]          os_q, os_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic [NUM_DATA_BITS-1:0] hold_q, hold_d;
    logic                     hold_v_q, hold_v_d;
    logic                     tx_q, tx_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     bit_end;
    logic                     accept;
    logic                     taken;
`ifdef UART_TX_PARITY_EN
    logic [NUM_DATA_BITS-1:0] byte_q, byte_d;
    localparam logic ODD = (PARITY_ODD != 0);
`endif

    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            os_q     <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            byte_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            os_q     <= os_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            byte_q   <= byte_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        busy_d   = busy_q;
        taken    = 1'b0;
`ifdef UART_TX_PARITY_EN
        byte_d   = byte_q;
`endif
        bit_end  = (os_q == OS_MAX);
        accept   = bus.start && ready_q;

        if (state_q != IDLE)
            os_d = bit_end ? '0 : os_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    taken   = 1'b1;
                    state_d = START_BIT;
                    shift_d = bus.data;
                    busy_d  = 1'b1;
                    os_d    = '0;
`ifdef UART_TX_PARITY_EN
                    byte_d  = bus.data;
`endif
                end
            end
            START_BIT: begin
                if (bit_end)
                    state_d = DATA_BITS;
            end
            DATA_BITS: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY_BIT;
`else
                        state_d = STOP_BIT;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_end)
                    state_d = STOP_BIT;
            end
`endif
            STOP_BIT: begin
                if (bit_end) begin
                    if (hold_v_q) begin
                        state_d  = START_BIT;
                        shift_d  = hold_q;
                        hold_v_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        byte_d   = hold_q;
`endif
                    end else if (accept) begin
                        // Byte offered exactly at frame end bypasses the
                        // holding register so the line never idles.
                        taken   = 1'b1;
                        state_d = START_BIT;
                        shift_d = bus.data;
`ifdef UART_TX_PARITY_EN
                        byte_d  = bus.data;
`endif
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept && !taken) begin
            hold_d   = bus.data;
            hold_v_d = 1'b1;
        end

        if (!bus.enable) begin
            state_d  = IDLE;
            os_d     = '0;
            bit_d    = '0;
            hold_v_d = 1'b0;
            busy_d   = 1'b0;
        end

        ready_d = bus.enable && !hold_v_d;
        // done covers the final oversample cycle of the stop bit.
        done_d  = bus.enable && (state_d == STOP_BIT) && (os_d == OS_MAX);

        // tx is registered, so it is decoded from the next state.
        unique case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: tx_d = (^byte_d) ^ ODD;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
